// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute handshake bundle for the branch predictor controller.
interface branch_pred_ctrl_if #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              lookup_v_i;
    logic [W_ADDR-1:0] lookup_pc_i;
    logic              lookup_rdy_o;
    logic              pred_v_o;
    logic              pred_taken_o;
    logic              resolve_v_i;
    logic              resolve_taken_i;
    logic              flush_o;
    logic [CW-1:0]     count_o;
    logic              err_o;

    // Fetch/execute side: issues lookups and resolves.
    modport master (
        output lookup_v_i, lookup_pc_i, resolve_v_i, resolve_taken_i,
        input  lookup_rdy_o, pred_v_o, pred_taken_o, flush_o, count_o, err_o
    );

    // Predictor side.
    modport slave (
        input  lookup_v_i, lookup_pc_i, resolve_v_i, resolve_taken_i,
        output lookup_rdy_o, pred_v_o, pred_taken_o, flush_o, count_o, err_o
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Bimodal branch predictor: 2-bit saturating counters plus an in-order queue of
// unresolved predictions; a mispredicting resolve clears the queue and flushes fetch.
module branch_pred_ctrl #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_IDX  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_pred_ctrl_if.slave  bp
);
    localparam int unsigned N_ENT = 2 ** W_IDX;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [W_IDX-1:0] idx;
        logic             pred;
    } entry_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q;
    logic [1:0]        ctr_q [N_ENT];
    entry_t            queue_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pred_v_q, pred_taken_q, flush_q, err_q;

    logic [W_IDX-1:0]  lookup_idx;
    entry_t            head;
    logic              have_entry, pop, mispredict, rdy, push;
    logic [1:0]        head_ctr_upd;
    logic              unused_pc;

    // PC word index selects the counter; other PC bits are ignored.
    assign lookup_idx = bp.lookup_pc_i[W_IDX+1:2];
    assign unused_pc  = ^{bp.lookup_pc_i[W_ADDR-1:W_IDX+2], bp.lookup_pc_i[1:0]};

    // Resolve qualification and lookup acceptance.
    assign head       = queue_q[rd_ptr_q];
    assign have_entry = (state_q == RUN) && (count_q != '0);
    assign pop        = bp.resolve_v_i && have_entry;
    assign mispredict = pop && (bp.resolve_taken_i != head.pred);
    assign rdy        = (state_q == RUN) && (count_q < CW'(DEPTH)) && !mispredict;
    assign push       = bp.lookup_v_i && rdy;

    // Saturating update of the counter belonging to the oldest entry.
    always_comb begin
        head_ctr_upd = ctr_q[head.idx];
        if (bp.resolve_taken_i) begin
            if (ctr_q[head.idx] != 2'b11) head_ctr_upd = ctr_q[head.idx] + 2'b01;
        end else begin
            if (ctr_q[head.idx] != 2'b00) head_ctr_upd = ctr_q[head.idx] - 2'b01;
        end
    end

    // Queue pointer and occupancy next-state; a mispredict empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = PW'(wr_ptr_q + PW'(1));
        if (pop)  rd_ptr_d = PW'(rd_ptr_q + PW'(1));
        if (push && !pop)      count_d = CW'(count_q + CW'(1));
        else if (!push && pop) count_d = CW'(count_q - CW'(1));
        if (mispredict) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State, counter table, queue storage and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pred_v_q     <= 1'b0;
            pred_taken_q <= 1'b0;
            flush_q      <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < int'(N_ENT); i++) ctr_q[i] <= 2'b01;
            for (int i = 0; i < int'(DEPTH); i++) queue_q[i] <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pred_v_q     <= push;
            pred_taken_q <= push & ctr_q[lookup_idx][1];
            flush_q      <= mispredict;
            if (push) queue_q[wr_ptr_q] <= '{idx: lookup_idx, pred: ctr_q[lookup_idx][1]};
            if (pop)  ctr_q[head.idx] <= head_ctr_upd;
            if (bp.resolve_v_i && !have_entry) err_q <= 1'b1;
            case (state_q)
                RUN:     if (mispredict) state_q <= FLUSH;
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign bp.lookup_rdy_o = rdy;
    assign bp.pred_v_o     = pred_v_q;
    assign bp.pred_taken_o = pred_taken_q;
    assign bp.flush_o      = flush_q;
    assign bp.count_o      = count_q;
    assign bp.err_o        = err_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: expected predictions are queued at issue
// and checked by an independent monitor whenever pred_v_o fires.
module tb_branch_pred_ctrl;
    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_IDX  = 4;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   exp_q [$];

    branch_pred_ctrl_if #(.W_ADDR(W_ADDR), .DEPTH(DEPTH)) bp ();

    branch_pred_ctrl #(.W_ADDR(W_ADDR), .W_IDX(W_IDX), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle, pop and compare on a prediction, else taken must be 0.
    always @(negedge clk) begin
        if (reset) begin
            if (bp.pred_v_o) begin
                if (exp_q.size() == 0) begin
                    check("pred_unexpected", 1, 0);
                end else begin
                    check("pred_taken", int'(bp.pred_taken_o), int'(exp_q.pop_front()));
                end
            end else begin
                check("pred_taken_idle", int'(bp.pred_taken_o), 0);
            end
        end
    end

    // One idle cycle, checking the observable state at its negedge.
    task automatic expect_state(input int cnt, input int rdy, input int fl, input int er);
        @(negedge clk);
        check("count_o", int'(bp.count_o), cnt);
        check("lookup_rdy_o", int'(bp.lookup_rdy_o), rdy);
        check("flush_o", int'(bp.flush_o), fl);
        check("err_o", int'(bp.err_o), er);
        @(posedge clk); #1;
    endtask

    task automatic do_lookup(input logic [W_ADDR-1:0] pc, input bit exp_taken);
        bp.lookup_v_i  = 1'b1;
        bp.lookup_pc_i = pc;
        @(negedge clk);
        check("lookup_accept", int'(bp.lookup_rdy_o), 1);
        exp_q.push_back(exp_taken);
        @(posedge clk); #1;
        bp.lookup_v_i = 1'b0;
    endtask

    task automatic do_resolve(input bit taken);
        bp.resolve_v_i     = 1'b1;
        bp.resolve_taken_i = taken;
        @(posedge clk); #1;
        bp.resolve_v_i = 1'b0;
    endtask

    // Simultaneous resolve and lookup in one cycle, queue not full.
    task automatic do_pair(input bit taken, input logic [W_ADDR-1:0] pc, input bit exp_taken);
        bp.resolve_v_i     = 1'b1;
        bp.resolve_taken_i = taken;
        bp.lookup_v_i      = 1'b1;
        bp.lookup_pc_i     = pc;
        @(negedge clk);
        check("pair_accept", int'(bp.lookup_rdy_o), 1);
        check("pair_count", int'(bp.count_o), 3);
        check("pair_no_flush", int'(bp.flush_o), 0);
        exp_q.push_back(exp_taken);
        @(posedge clk); #1;
        bp.resolve_v_i = 1'b0;
        bp.lookup_v_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors            = 0;
        miscompares        = 0;
        reset              = 1'b0;
        bp.lookup_v_i      = 1'b0;
        bp.lookup_pc_i     = '0;
        bp.resolve_v_i     = 1'b0;
        bp.resolve_taken_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pred_v", int'(bp.pred_v_o), 0);
        check("rst_pred_taken", int'(bp.pred_taken_o), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        expect_state(0, 1, 0, 0);

        // First lookup after reset predicts weakly not-taken.
        do_lookup(32'h10, 1'b0);
        expect_state(1, 1, 0, 0);

        // Taken resolve mispredicts: counter 01->10, flush, one blocked cycle.
        do_resolve(1'b1);
        expect_state(0, 0, 1, 0);
        expect_state(0, 1, 0, 0);
        do_lookup(32'h10, 1'b1);
        do_resolve(1'b1);              // 10->11, correct
        expect_state(0, 1, 0, 0);
        do_lookup(32'h10, 1'b1);
        do_resolve(1'b1);              // stays 11
        do_lookup(32'h10, 1'b1);       // still taken: saturated, not wrapped
        do_resolve(1'b1);
        expect_state(0, 1, 0, 0);

        // Mispredict with two entries outstanding (idx 8, counter 01).
        do_lookup(32'h20, 1'b0);
        do_lookup(32'h20, 1'b0);
        expect_state(2, 1, 0, 0);
        do_resolve(1'b1);              // idx 8 -> 10
        expect_state(0, 0, 1, 0);
        expect_state(0, 1, 0, 0);

        // Fill the queue; a pop does not reopen lookup in the same cycle.
        for (int i = 0; i < 4; i++) do_lookup(32'h0, 1'b0);
        expect_state(4, 0, 0, 0);
        bp.resolve_v_i     = 1'b1;
        bp.resolve_taken_i = 1'b0;     // correct; idx 0 -> 00
        bp.lookup_v_i      = 1'b1;
        bp.lookup_pc_i     = 32'h0;
        @(negedge clk);
        check("full_pop_rdy", int'(bp.lookup_rdy_o), 0);
        @(posedge clk); #1;
        bp.resolve_v_i = 1'b0;
        @(negedge clk);
        check("after_pop_rdy", int'(bp.lookup_rdy_o), 1);
        check("after_pop_count", int'(bp.count_o), 3);
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        bp.lookup_v_i = 1'b0;
        for (int i = 0; i < 4; i++) do_resolve(1'b0);
        expect_state(0, 1, 0, 0);

        // Empty-queue resolves: sticky error, counters untouched.
        do_resolve(1'b1);
        expect_state(0, 1, 0, 1);
        do_resolve(1'b1);
        expect_state(0, 1, 0, 1);
        do_lookup(32'h0, 1'b0);        // idx 0 still 00
        do_resolve(1'b0);
        do_lookup(32'h30, 1'b0);       // idx 12 still 01
        do_resolve(1'b0);              // idx 12 -> 00

        // Eight push/pop pairs across pointer wrap; counters: c4=11 c0=00 c8=10 c12=00.
        do_lookup(32'h10, 1'b1);
        do_lookup(32'h00, 1'b0);
        do_lookup(32'h20, 1'b1);
        do_pair(1'b1, 32'h30, 1'b0);
        do_pair(1'b0, 32'h10, 1'b1);
        do_pair(1'b1, 32'h00, 1'b0);   // c8 -> 11
        do_pair(1'b0, 32'h20, 1'b1);
        do_pair(1'b1, 32'h30, 1'b0);
        do_pair(1'b0, 32'h10, 1'b1);
        do_pair(1'b1, 32'h00, 1'b0);
        do_pair(1'b0, 32'h20, 1'b1);
        do_resolve(1'b1);
        do_resolve(1'b0);
        do_resolve(1'b1);
        expect_state(0, 1, 0, 1);

        // Reset mid-operation drops outstanding entries without a flush.
        do_lookup(32'h0, 1'b0);
        do_lookup(32'h0, 1'b0);
        expect_state(2, 1, 0, 1);
        reset = 1'b0;
        #2;
        check("midrst_count", int'(bp.count_o), 0);
        check("midrst_flush", int'(bp.flush_o), 0);
        check("midrst_err", int'(bp.err_o), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        expect_state(0, 1, 0, 0);
        do_lookup(32'h10, 1'b0);       // idx 4 back to 01
        expect_state(1, 1, 0, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL take parameter W_ADDR, default 32, meaning fetch PC width.
REQ-002 SHALL take parameter W_IDX, default 4, meaning table index width; table holds 2**W_IDX entries.
REQ-003 SHALL take parameter DEPTH, default 4, meaning maximum outstanding unresolved predictions (power of two).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port lookup_v_i  input  1  fetch requests a prediction.
REQ-007 SHALL have port lookup_pc_i  input  W_ADDR  PC of fetched branch; index = lookup_pc_i[W_IDX+1:2].
REQ-008 SHALL have port lookup_rdy_o  output  1  lookup accepted this cycle when high with lookup_v_i.
REQ-009 SHALL have port pred_v_o  output  1  prediction valid, one-cycle pulse.
REQ-010 SHALL have port pred_taken_o  output  1  predicted direction.
REQ-011 SHALL have port resolve_v_i  input  1  execute resolves the oldest outstanding branch.
REQ-012 SHALL have port resolve_taken_i  input  1  actual direction of that branch.
REQ-013 SHALL have port flush_o  output  1  mispredict flush pulse to fetch.
REQ-014 SHALL have port count_o  output  log2(DEPTH)+1  outstanding prediction count.
REQ-015 SHALL have port err_o  output  1  sticky: resolve received with empty queue.

Function
REQ-016 SHALL hold 2**W_IDX 2-bit saturating counters; prediction = counter bit 1.
REQ-017 SHALL hold an in-order queue of DEPTH entries, each storing {index, predicted bit}, with wrapping read/write pointers.
REQ-018 SHALL implement FSM states RUN and FLUSH; reset state RUN.
REQ-019 SHALL drive lookup_rdy_o = (state==RUN) & (count_o<DEPTH) & ~(resolve_v_i & mispredict), where mispredict = resolve_taken_i != predicted bit of oldest entry.
REQ-020 On accepted lookup, SHALL push {index, counter[index][1]} and assert pred_v_o with pred_taken_o = that bit exactly one cycle later (latency 1).
REQ-021 When pred_v_o is low, pred_taken_o SHALL be 0.
REQ-022 On resolve_v_i with count_o>0, SHALL pop the oldest entry and update its counter: taken -> +1 saturating at 3; not-taken -> -1 saturating at 0.
REQ-023 Simultaneous accepted lookup and resolve SHALL leave count_o unchanged; lookup reads the counter value before that cycle's update, including same index.
REQ-024 lookup_rdy_o SHALL be low while count_o==DEPTH even if a resolve pops in the same cycle.
REQ-025 On mispredicting resolve, SHALL update the counter, clear the queue (count_o=0 next cycle), pulse flush_o the next cycle, and enter FLUSH.
REQ-026 FLUSH SHALL last exactly one cycle, then return to RUN; resolves during FLUSH SHALL be treated as empty-queue resolves.
REQ-027 A resolve with count_o==0 SHALL change no counter and no pointer, and SHALL set err_o.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; queue order preserved across wrap.

Reset
REQ-029 Reset SHALL set every counter to 2'b01 (weakly not-taken), pointers and count_o to 0, state RUN, pred_v_o, pred_taken_o, flush_o, err_o to 0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding entries immediately, with no flush_o pulse.

Verification
REQ-031 Post-reset lookup PC 0x10 -> next cycle pred_v_o=1, pred_taken_o=0, count_o=1.
REQ-032 Two taken resolves for PC 0x10 (counter 01->10->11), then lookup 0x10 -> pred_taken_o=1; third taken resolve keeps counter 11.
REQ-033 Four lookups, no resolves -> count_o=4, lookup_rdy_o=0; one resolve with lookup_v_i held -> lookup accepted next cycle, not same cycle.
REQ-034 Lookup predicted 0, resolve taken=1 with two entries outstanding -> flush_o=1 next cycle, count_o=0, lookup_rdy_o=0 for one cycle, then 1.
REQ-035 Resolve with empty queue -> err_o=1 and stays 1; counters unchanged (lookup still predicts 0).
REQ-036 Eight push/pop pairs through DEPTH=4 queue -> pops update counters in push order; no flush when predictions correct.
